// File: rtl/frame_reception.sv
// frame_reception: byte-serial Ethernet-style frame receiver.
// Hunts for preamble + SFD, filters on destination address and EtherType,
// captures source address, EtherType and a 32-bit payload word, and checks
// a 4-byte frame check sequence. Each frame ends with a one-cycle rx_valid
// (fields updated) or a one-cycle rx_error with a cause code.
//
// Ports:
//   clk          - single clock
//   rst_n        - synchronous active-low reset
//   rx_in        - received byte
//   rx_dv        - rx_in valid; high for the whole frame
//   data_out     - payload word, first byte in [31:24]
//   src_addr_out - source address, first byte in [47:40]
//   eth_type_out - EtherType, first byte in [15:8]
//   rx_valid     - one-cycle good-frame pulse
//   rx_error     - one-cycle frame-error pulse
//   err_code     - 00 none, 01 FCS mismatch, 10 truncated, 11 EtherType mismatch
//   busy         - receiver is not idle
module frame_reception #(
  parameter logic [47:0] LOCAL_ADDR   = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [15:0] ETH_TYPE     = 16'h0800,
  parameter int unsigned MIN_PREAMBLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_in,
  input  logic        rx_dv,
  output logic [31:0] data_out,
  output logic [47:0] src_addr_out,
  output logic [15:0] eth_type_out,
  output logic        rx_valid,
  output logic        rx_error,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned PRE_W  = 4;

  localparam logic [BYTE_W-1:0] PRE_BYTE   = 8'h55;
  localparam logic [BYTE_W-1:0] SFD_BYTE   = 8'hD5;
  localparam logic [PRE_W-1:0]  PRE_MAX    = 4'hF;
  localparam logic [PRE_W-1:0]  PRE_MIN    = PRE_W'(MIN_PREAMBLE);
  localparam logic [31:0]       FCS_SEED   = 32'hFFFF_FFFF;
  localparam logic [47:0]       BCAST_ADDR = 48'hFFFF_FFFF_FFFF;

  localparam logic [CNT_W-1:0] DEST_LAST = 3'd5;
  localparam logic [CNT_W-1:0] SRC_LAST  = 3'd5;
  localparam logic [CNT_W-1:0] TYPE_LAST = 3'd1;
  localparam logic [CNT_W-1:0] PAY_LAST  = 3'd3;
  localparam logic [CNT_W-1:0] FCS_LAST  = 3'd3;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_FCS   = 2'b01;
  localparam logic [1:0] ERR_TRUNC = 2'b10;
  localparam logic [1:0] ERR_TYPE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DEST,
    S_SRC,
    S_TYPE,
    S_PAYLOAD,
    S_FCS,
    S_DROP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [39:0]        dst_q, dst_d;
  logic [47:0]        src_q, src_d;
  logic [15:0]        type_q, type_d;
  logic [31:0]        data_q, data_d;
  logic [23:0]        fcs_shift_q, fcs_shift_d;
  logic [31:0]        fcs_calc_q, fcs_calc_d;

  logic [31:0]        data_out_d;
  logic [47:0]        src_addr_out_d;
  logic [15:0]        eth_type_out_d;
  logic               rx_valid_d;
  logic               rx_error_d;
  logic [1:0]         err_code_d;
  logic               busy_d;

  logic [47:0]        dest_word;
  logic               addr_ok;
  logic               in_frame;

  // Full destination as it stands once the 6th byte arrives.
  assign dest_word = {dst_q, rx_in};
  assign addr_ok   = (dest_word == LOCAL_ADDR) ||
                     (ACCEPT_BCAST && (dest_word == BCAST_ADDR));
  // States in which an rx_dv drop means the frame was cut short.
  assign in_frame  = (state_q == S_DEST)    || (state_q == S_SRC) ||
                     (state_q == S_TYPE)    || (state_q == S_PAYLOAD) ||
                     (state_q == S_FCS);

  // Next-state, datapath and output decode.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    pre_d           = pre_q;
    dst_d           = dst_q;
    src_d           = src_q;
    type_d          = type_q;
    data_d          = data_q;
    fcs_shift_d     = fcs_shift_q;
    fcs_calc_d      = fcs_calc_q;
    data_out_d      = data_out;
    src_addr_out_d  = src_addr_out;
    eth_type_out_d  = eth_type_out;
    rx_valid_d      = 1'b0;
    rx_error_d      = 1'b0;
    err_code_d      = err_code;

    if (in_frame && !rx_dv) begin
      state_d    = S_IDLE;
      rx_error_d = 1'b1;
      err_code_d = ERR_TRUNC;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_dv && (rx_in == PRE_BYTE)) begin
            state_d = S_PREAMBLE;
            pre_d   = PRE_W'(1);
          end
        end

        S_PREAMBLE: begin
          if (!rx_dv) begin
            state_d = S_IDLE;
          end else if (rx_in == PRE_BYTE) begin
            if (pre_q != PRE_MAX) pre_d = pre_q + 4'd1;
          end else if ((rx_in == SFD_BYTE) && (pre_q >= PRE_MIN)) begin
            state_d    = S_DEST;
            fcs_calc_d = FCS_SEED;
          end else begin
            state_d = S_IDLE;
          end
        end

        S_DEST: begin
          dst_d = {dst_q[31:0], rx_in};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == DEST_LAST) state_d = addr_ok ? S_SRC : S_DROP;
        end

        S_SRC: begin
          src_d = {src_q[39:0], rx_in};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == SRC_LAST) state_d = S_TYPE;
        end

        S_TYPE: begin
          type_d = {type_q[7:0], rx_in};
          cnt_d  = cnt_q + 3'd1;
          if (cnt_q == TYPE_LAST) begin
            if ({type_q[7:0], rx_in} != ETH_TYPE) begin
              state_d    = S_DROP;
              rx_error_d = 1'b1;
              err_code_d = ERR_TYPE;
            end else begin
              state_d = S_PAYLOAD;
            end
          end
        end

        S_PAYLOAD: begin
          // Only payload bytes feed the check value; the seed shifts out.
          data_d     = {data_q[23:0], rx_in};
          fcs_calc_d = (fcs_calc_q << 8) ^ {24'h0, rx_in};
          cnt_d      = cnt_q + 3'd1;
          if (cnt_q == PAY_LAST) state_d = S_FCS;
        end

        S_FCS: begin
          fcs_shift_d = {fcs_shift_q[15:0], rx_in};
          cnt_d       = cnt_q + 3'd1;
          if (cnt_q == FCS_LAST) begin
            state_d = S_DROP;
            if ({fcs_shift_q, rx_in} == fcs_calc_q) begin
              rx_valid_d     = 1'b1;
              err_code_d     = ERR_NONE;
              data_out_d     = data_q;
              src_addr_out_d = src_q;
              eth_type_out_d = type_q;
            end else begin
              rx_error_d = 1'b1;
              err_code_d = ERR_FCS;
            end
          end
        end

        S_DROP: begin
          if (!rx_dv) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end

    // Byte counter restarts on every state change.
    if (state_d != state_q) cnt_d = '0;

    busy_d = (state_d != S_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pre_q        <= '0;
      dst_q        <= '0;
      src_q        <= '0;
      type_q       <= '0;
      data_q       <= '0;
      fcs_shift_q  <= '0;
      fcs_calc_q   <= FCS_SEED;
      data_out     <= '0;
      src_addr_out <= '0;
      eth_type_out <= '0;
      rx_valid     <= 1'b0;
      rx_error     <= 1'b0;
      err_code     <= ERR_NONE;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pre_q        <= pre_d;
      dst_q        <= dst_d;
      src_q        <= src_d;
      type_q       <= type_d;
      data_q       <= data_d;
      fcs_shift_q  <= fcs_shift_d;
      fcs_calc_q   <= fcs_calc_d;
      data_out     <= data_out_d;
      src_addr_out <= src_addr_out_d;
      eth_type_out <= eth_type_out_d;
      rx_valid     <= rx_valid_d;
      rx_error     <= rx_error_d;
      err_code     <= err_code_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_frame_reception.sv
// Testbench for frame_reception: directed scenarios plus randomized frames,
// all checked every cycle against a byte-position based reference model.
module tb_frame_reception;

  localparam logic [47:0] LOCAL = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] ETYPE = 16'h0800;
  localparam int          MINPRE = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_in = 8'h00;
  logic [31:0] data_out;
  logic [47:0] src_addr_out;
  logic [15:0] eth_type_out;
  logic        rx_valid;
  logic        rx_error;
  logic [1:0]  err_code;
  logic        busy;

  always #5 clk = ~clk;

  frame_reception #(
    .LOCAL_ADDR  (LOCAL),
    .ACCEPT_BCAST(1'b1),
    .ETH_TYPE    (ETYPE),
    .MIN_PREAMBLE(MINPRE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_in       (rx_in),
    .rx_dv       (rx_dv),
    .data_out    (data_out),
    .src_addr_out(src_addr_out),
    .eth_type_out(eth_type_out),
    .rx_valid    (rx_valid),
    .rx_error    (rx_error),
    .err_code    (err_code),
    .busy        (busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 hunting, 1 counting preamble, 2 inside frame
  // body (m_idx bytes after SFD), 3 discarding until rx_dv drops.
  int          m_mode = 0;
  int          m_pre  = 0;
  int          m_idx  = 0;
  logic [7:0]  m_body [22];
  logic        e_valid = 1'b0;
  logic        e_error = 1'b0;
  logic [1:0]  e_code  = 2'b00;
  logic        e_busy  = 1'b0;
  logic [31:0] e_data  = '0;
  logic [47:0] e_src   = '0;
  logic [15:0] e_type  = '0;

  logic [7:0]  fq[$];

  function automatic logic [47:0] body_field(int lo, int n);
    logic [47:0] r = '0;
    for (int i = 0; i < n; i++) r = (r << 8) | 48'(m_body[lo + i]);
    return r;
  endfunction

  // Check value for a payload word: seeded with all ones, each byte shifted in.
  function automatic logic [31:0] fcs_of(logic [31:0] pay);
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 3; i >= 0; i--) c = (c << 8) ^ {24'h0, pay[i*8 +: 8]};
    return c;
  endfunction

  task automatic model_step(input logic r, input logic dv, input logic [7:0] b);
    logic [47:0] dst;
    logic [31:0] calc;
    e_valid = 1'b0;
    e_error = 1'b0;
    if (!r) begin
      m_mode = 0; m_pre = 0; m_idx = 0;
      e_code = 2'b00; e_data = '0; e_src = '0; e_type = '0;
    end else begin
      case (m_mode)
        0: if (dv && b == 8'h55) begin m_mode = 1; m_pre = 1; end
        1: begin
          if (!dv) m_mode = 0;
          else if (b == 8'h55) m_pre = (m_pre < 15) ? m_pre + 1 : 15;
          else if (b == 8'hD5 && m_pre >= MINPRE) begin m_mode = 2; m_idx = 0; end
          else m_mode = 0;
        end
        2: begin
          if (!dv) begin
            m_mode = 0; e_error = 1'b1; e_code = 2'b10;
          end else begin
            m_body[m_idx] = b;
            m_idx++;
            if (m_idx == 6) begin
              dst = body_field(0, 6);
              if (!(dst == LOCAL || dst == BCAST)) m_mode = 3;
            end else if (m_idx == 14) begin
              if (16'(body_field(12, 2)) != ETYPE) begin
                m_mode = 3; e_error = 1'b1; e_code = 2'b11;
              end
            end else if (m_idx == 22) begin
              m_mode = 3;
              calc = fcs_of(32'(body_field(14, 4)));
              if (32'(body_field(18, 4)) == calc) begin
                e_valid = 1'b1; e_code = 2'b00;
                e_data  = 32'(body_field(14, 4));
                e_src   = body_field(6, 6);
                e_type  = 16'(body_field(12, 2));
              end else begin
                e_error = 1'b1; e_code = 2'b01;
              end
            end
          end
        end
        default: if (!dv) m_mode = 0;
      endcase
    end
    e_busy = (m_mode != 0);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive, let both DUT and model take the edge, compare mid-cycle.
  task automatic cyc(input logic r, input logic dv, input logic [7:0] b);
    rst_n = r; rx_dv = dv; rx_in = b;
    @(posedge clk);
    model_step(r, dv, b);
    @(negedge clk);
    chk("cycle {valid,error,code,busy,type,src,data}",
        {27'b0, rx_valid, rx_error, err_code, busy, eth_type_out, src_addr_out, data_out},
        {27'b0, e_valid, e_error, e_code, e_busy, e_type, e_src, e_data});
  endtask

  task automatic build(input int npre, input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] ty, input logic [31:0] pay, input logic [31:0] fcs);
    fq.delete();
    for (int i = 0; i < npre; i++) fq.push_back(8'h55);
    fq.push_back(8'hD5);
    for (int i = 5; i >= 0; i--) fq.push_back(dst[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) fq.push_back(src[i*8 +: 8]);
    for (int i = 1; i >= 0; i--) fq.push_back(ty[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fq.push_back(pay[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) fq.push_back(fcs[i*8 +: 8]);
  endtask

  // Send fq[lo..hi-1] with rx_dv high; a reset is applied on byte rst_at.
  task automatic send_range(input int lo, input int hi, input int rst_at);
    for (int i = lo; i < hi; i++) cyc(i != rst_at, 1'b1, fq[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'(($urandom)));
  endtask

  initial begin
    int          npre, sel, tcut, rat, ntr;
    logic [47:0] dst, src;
    logic [15:0] ty;
    logic [31:0] pay, fcs;

    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    chk("reset_outputs", {rx_valid, rx_error, err_code, busy, eth_type_out, src_addr_out, data_out}, '0);
    idle(2);

    // Good broadcast frame with the transmitter's default preamble.
    build(8, BCAST, 48'hAABB_CCDD_EEFF, 16'h0800, 32'h1234_5678, 32'h1234_5678);
    send_range(0, fq.size(), -1);
    chk("good_valid", rx_valid, 1);
    chk("good_data", data_out, 32'h1234_5678);
    chk("good_src", src_addr_out, 48'hAABB_CCDD_EEFF);
    chk("good_type", eth_type_out, 16'h0800);
    chk("good_code", err_code, 2'b00);
    idle(1);
    chk("good_pulse_width", rx_valid, 0);

    // Last FCS byte corrupted.
    build(8, BCAST, 48'hAABB_CCDD_EEFF, 16'h0800, 32'h1234_5678, 32'h1234_5679);
    send_range(0, fq.size(), -1);
    chk("fcs_error", {rx_valid, rx_error}, 2'b01);
    chk("fcs_code", err_code, 2'b01);
    chk("fcs_data_held", data_out, 32'h1234_5678);
    idle(1);
    chk("fcs_code_holds", err_code, 2'b01);

    // rx_dv drops right after payload byte 34.
    build(8, BCAST, 48'hAABB_CCDD_EEFF, 16'h0800, 32'h1234_5678, 32'h1234_5678);
    send_range(0, 25, -1);
    idle(1);
    chk("trunc_error", {rx_valid, rx_error}, 2'b01);
    chk("trunc_code", err_code, 2'b10);
    idle(1);
    chk("trunc_busy_low", busy, 0);

    // Foreign destination is filtered silently, then a broadcast frame passes.
    build(8, 48'h0102_0304_0506, 48'hAABB_CCDD_EEFF, 16'h0800, 32'h1234_5678, 32'h1234_5678);
    send_range(0, fq.size(), -1);
    chk("filter_no_pulse", {rx_valid, rx_error}, 2'b00);
    chk("filter_busy", busy, 1);
    idle(1);
    build(8, BCAST, 48'h1122_3344_5566, 16'h0800, 32'hCAFE_BABE, fcs_of(32'hCAFE_BABE));
    send_range(0, fq.size(), -1);
    chk("bcast_valid", rx_valid, 1);
    chk("bcast_data", data_out, 32'hCAFE_BABE);
    chk("bcast_src", src_addr_out, 48'h1122_3344_5566);
    idle(1);

    // Single preamble byte is below the minimum: frame ignored.
    build(1, BCAST, 48'hAABB_CCDD_EEFF, 16'h0800, 32'h1234_5678, 32'h1234_5678);
    send_range(0, fq.size(), -1);
    chk("short_pre_quiet", {rx_valid, rx_error, busy}, 3'b000);
    chk("short_pre_data_held", data_out, 32'hCAFE_BABE);
    idle(1);

    // Wrong EtherType: error one cycle after byte DD.
    build(8, BCAST, 48'hAABB_CCDD_EEFF, 16'h86DD, 32'h1234_5678, 32'h1234_5678);
    send_range(0, 23, -1);
    chk("type_error", {rx_valid, rx_error}, 2'b01);
    chk("type_code", err_code, 2'b11);
    send_range(23, fq.size(), -1);
    idle(1);

    // Reset during the source address, then a minimum-preamble frame.
    build(8, LOCAL, 48'hAABB_CCDD_EEFF, 16'h0800, 32'h1234_5678, 32'h1234_5678);
    send_range(0, 18, 17);
    chk("midreset_zero", {rx_valid, rx_error, err_code, busy, eth_type_out, src_addr_out, data_out}, '0);
    send_range(18, fq.size(), -1);
    idle(1);
    build(MINPRE, LOCAL, 48'h0A0B_0C0D_0E0F, 16'h0800, 32'hDEAD_BEEF, fcs_of(32'hDEAD_BEEF));
    send_range(0, fq.size(), -1);
    chk("after_reset_valid", rx_valid, 1);
    chk("after_reset_data", data_out, 32'hDEAD_BEEF);
    chk("after_reset_src", src_addr_out, 48'h0A0B_0C0D_0E0F);
    chk("after_reset_type", eth_type_out, 16'h0800);
    idle(1);

    // Randomized frames with noise, filtering, corruption, truncation and resets.
    for (int n = 0; n < 200; n++) begin
      npre = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 6));
      sel  = int'($urandom_range(0, 3));
      dst  = (sel == 0) ? LOCAL : (sel == 1) ? BCAST :
             (sel == 2) ? {$urandom, $urandom} : (LOCAL ^ (48'h1 << $urandom_range(0, 47)));
      src  = {$urandom, $urandom};
      ty   = ($urandom_range(0, 4) == 0) ? 16'($urandom) : ETYPE;
      pay  = $urandom;
      fcs  = fcs_of(pay);
      if ($urandom_range(0, 3) == 0) fcs = fcs ^ (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 4) == 0)
        for (int k = 0; k < int'($urandom_range(1, 4)); k++) cyc(1'b1, 1'b1, 8'($urandom));
      build(npre, dst, src, ty, pay, fcs);
      rat = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, fq.size() - 1)) : -1;
      if ($urandom_range(0, 6) == 0) begin
        tcut = int'($urandom_range(npre + 1, fq.size() - 1));
        send_range(0, tcut, rat);
      end else begin
        send_range(0, fq.size(), rat);
        ntr = int'($urandom_range(0, 3));
        for (int k = 0; k < ntr; k++) cyc(1'b1, 1'b1, 8'($urandom));
      end
      idle(int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
